// File: rtl/pipe_stage_em.sv
// pipe_stage_em: E->M pipeline register with valid/ready handshake.
// Define PIPE_STAGE_EM_SKID_EN for a registered ReadyE backed by a second (skid) slot.
module pipe_stage_em #(
  parameter int SIZE = 32,
  parameter int RW   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ValidE,
  output logic            ReadyE,
  input  logic            FlushE,
  input  logic            PCSrcE2,
  input  logic            RegWriteE2,
  input  logic            MemToRegE,
  input  logic            MemWriteE2,
  input  logic [RW-1:0]   WA3E,
  input  logic [SIZE-1:0] ALUResultE,
  input  logic [SIZE-1:0] WriteDataE,
  output logic            ValidM,
  input  logic            ReadyM,
  output logic            PCSrcM,
  output logic            RegWriteM,
  output logic            MemToRegM,
  output logic            MemWriteM,
  output logic [RW-1:0]   WA3M,
  output logic [SIZE-1:0] ALUOutM,
  output logic [SIZE-1:0] WriteDataM
);
  typedef struct packed {
    logic            pcsrc;
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
    logic [RW-1:0]   wa3;
    logic [SIZE-1:0] alu;
    logic [SIZE-1:0] wd;
  } entry_t;
  entry_t in_e, main_q;
  logic   valid_q, push, pop;
  assign in_e = {PCSrcE2, RegWriteE2, MemToRegE, MemWriteE2, WA3E, ALUResultE, WriteDataE};
  assign push = ValidE && ReadyE;
  assign pop  = valid_q && ReadyM;
`ifdef PIPE_STAGE_EM_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q;
  entry_t skid_q;
  logic   ready_q;
  assign valid_q = state_q != EMPTY;
  assign ReadyE  = ready_q;
  // ready_q tracks "next state is not TWO" so ReadyE never depends on ReadyM combinationally
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (FlushE) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_q  <= in_e;
          state_q <= ONE;
        end
        ONE: if (push && pop) main_q <= in_e;
        else if (pop) state_q <= EMPTY;
        else if (push) begin
          skid_q  <= in_e;
          state_q <= TWO;
          ready_q <= 1'b0;
        end
        TWO: if (pop) begin
          main_q  <= skid_q;
          state_q <= ONE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  assign ReadyE = !valid_q || ReadyM;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (FlushE) valid_q <= 1'b0;
    else if (push) begin
      main_q  <= in_e;
      valid_q <= 1'b1;
    end else if (pop) valid_q <= 1'b0;
  end
`endif
  assign ValidM     = valid_q;
  assign PCSrcM     = valid_q && main_q.pcsrc;
  assign RegWriteM  = valid_q && main_q.regwrite;
  assign MemWriteM  = valid_q && main_q.memwrite;
  assign MemToRegM  = main_q.memtoreg;
  assign WA3M       = main_q.wa3;
  assign ALUOutM    = main_q.alu;
  assign WriteDataM = main_q.wd;
endmodule
